// File: rtl/amm_burst_slave.sv
// Avalon-MM burst slave over an internal byte-enabled RAM, with a queued read engine.
// Optional `RND_WAITREQ_EN adds an LFSR-driven random stall on waitrequest.
module amm_burst_slave #(
  parameter int unsigned AMM_ADDR_W  = 28,
  parameter int unsigned AMM_DATA_W  = 128,
  parameter int unsigned AMM_BURST_W = 11,
  parameter int unsigned MEM_WORDS_W = 10,
  parameter int unsigned CMD_FIFO_D  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AMM_ADDR_W-1:0]     amm_address_i,
  input  logic                      amm_read_i,
  input  logic                      amm_write_i,
  input  logic [AMM_DATA_W-1:0]     amm_writedata_i,
  input  logic [AMM_DATA_W/8-1:0]   amm_byteenable_i,
  input  logic [AMM_BURST_W-1:0]    amm_burstcount_i,
  output logic                      amm_waitrequest_o,
  output logic [AMM_DATA_W-1:0]     amm_readdata_o,
  output logic                      amm_readdatavalid_o,
  output logic                      prot_err_o
);

  localparam int unsigned DATA_B_W = AMM_DATA_W / 8;
  localparam int unsigned MEM_D    = 1 << MEM_WORDS_W;
  localparam int unsigned PTR_W    = (CMD_FIFO_D > 1) ? $clog2(CMD_FIFO_D) : 1;
  localparam int unsigned CNT_W    = $clog2(CMD_FIFO_D + 1);

  typedef logic [MEM_WORDS_W-1:0] maddr_t;
  typedef logic [AMM_BURST_W-1:0] bcnt_t;
  typedef logic [PTR_W-1:0]       ptr_t;
  typedef logic [CNT_W-1:0]       cnt_t;
  typedef enum logic {W_IDLE, W_BURST} wstate_t;

  localparam maddr_t ADDR_ONE  = maddr_t'(1);
  localparam bcnt_t  BC_ONE    = bcnt_t'(1);
  localparam bcnt_t  MAX_BURST = {1'b1, {(AMM_BURST_W-1){1'b0}}};
  localparam ptr_t   PTR_ONE   = ptr_t'(1);
  localparam ptr_t   PTR_LAST  = ptr_t'(CMD_FIFO_D - 1);
  localparam cnt_t   CNT_ONE   = cnt_t'(1);
  localparam cnt_t   CNT_FULL  = cnt_t'(CMD_FIFO_D);

  logic [AMM_DATA_W-1:0] mem [MEM_D];
  maddr_t                fifo_addr [CMD_FIFO_D];
  bcnt_t                 fifo_bc   [CMD_FIFO_D];

  wstate_t wstate;
  maddr_t  waddr, raddr, addr_lo, mem_wa, rd_addr;
  bcnt_t   wrem, rrem;
  ptr_t    wr_ptr, rd_ptr;
  cnt_t    fifo_cnt;
  logic    init_q, rbusy, stall_rnd, bc_ok, wr_acc, rd_acc, push, pop, issue;
  logic    mem_we, cmd_err, fifo_full;
  logic    unused_addr_hi;

  assign unused_addr_hi = &{1'b0, amm_address_i[AMM_ADDR_W-1:MEM_WORDS_W]};

`ifdef RND_WAITREQ_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  assign stall_rnd = lfsr_q[0];
`else
  assign stall_rnd = 1'b0;
`endif

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_comb begin
    addr_lo   = amm_address_i[MEM_WORDS_W-1:0];
    fifo_full = (fifo_cnt == CNT_FULL);
    bc_ok     = (amm_burstcount_i != '0) && (amm_burstcount_i <= MAX_BURST);
    amm_waitrequest_o = init_q | stall_rnd
                      | (amm_read_i & fifo_full)
                      | (amm_read_i & (wstate == W_BURST));
    wr_acc  = amm_write_i & ~amm_waitrequest_o;
    // A read paired with a write is never queued; the write wins.
    rd_acc  = amm_read_i & ~amm_write_i & ~amm_waitrequest_o;
    push    = rd_acc & bc_ok;
    cmd_err = (amm_read_i & amm_write_i & ~amm_waitrequest_o)
            | (((wr_acc & (wstate == W_IDLE)) | rd_acc) & ~bc_ok);
    mem_we  = wr_acc & ((wstate == W_BURST) | bc_ok);
    mem_wa  = (wstate == W_BURST) ? waddr : addr_lo;
    pop     = ~rbusy & (fifo_cnt != '0);
    issue   = rbusy | pop;
    rd_addr = rbusy ? raddr : fifo_addr[rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < DATA_B_W; b++) begin
        if (amm_byteenable_i[b]) mem[mem_wa][b*8 +: 8] <= amm_writedata_i[b*8 +: 8];
      end
    end
    if (push) begin
      fifo_addr[wr_ptr] <= addr_lo;
      fifo_bc[wr_ptr]   <= amm_burstcount_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wstate <= W_IDLE;
      waddr  <= '0;
      wrem   <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (wr_acc && bc_ok && amm_burstcount_i != BC_ONE) begin
          waddr  <= addr_lo + ADDR_ONE;
          wrem   <= amm_burstcount_i - BC_ONE;
          wstate <= W_BURST;
        end
        W_BURST: if (wr_acc) begin
          waddr <= waddr + ADDR_ONE;
          wrem  <= wrem - BC_ONE;
          if (wrem == BC_ONE) wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // The RAM read is issued in the pop cycle itself, so consecutive bursts stream without a gap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_q              <= 1'b1;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_cnt            <= '0;
      rbusy               <= 1'b0;
      raddr               <= '0;
      rrem                <= '0;
      amm_readdatavalid_o <= 1'b0;
      amm_readdata_o      <= '0;
      prot_err_o          <= 1'b0;
    end else begin
      init_q <= 1'b0;
      if (cmd_err) prot_err_o <= 1'b1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
      amm_readdatavalid_o <= issue;
      if (issue) amm_readdata_o <= mem[rd_addr];
      if (pop) begin
        raddr <= fifo_addr[rd_ptr] + ADDR_ONE;
        rrem  <= fifo_bc[rd_ptr] - BC_ONE;
        rbusy <= (fifo_bc[rd_ptr] != BC_ONE);
      end else if (rbusy) begin
        raddr <= raddr + ADDR_ONE;
        rrem  <= rrem - BC_ONE;
        if (rrem == BC_ONE) rbusy <= 1'b0;
      end
    end
  end

endmodule
